async_counter_4bit: RTL and testbench
=====================================

// Module: async_counter_4bit
// PURPOSE
//   WIDTH-bit asynchronous (ripple) up-counter with an asynchronous active-low reset.
//   Stage 0 toggles on the rising edge of clk; each later stage is clocked by the previous stage's output.
//   Used as a small free-running event/cycle counter wherever ripple settling delay is acceptable.
// PARAMETERS
//   WIDTH  4  number of counter stages; the counter range is 0 .. 2^WIDTH-1.
// PORTS
//   clk  input   1      count clock; each rising edge advances the count by one.
//   rst  input   1      reset; asynchronous, active-low (0 = reset asserted).
//   q    output  WIDTH  current count; q[0] is the LSB.
//   tc   output  1      terminal count; present only with ASYNC_COUNTER_TC_EN.
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//   - Structure:
//     - WIDTH toggle flip-flops.
//     - Stage 0 toggles on posedge clk.
//     - Stage i (i >= 1) toggles when q[i-1] falls 1->0, e.g. a posedge flop clocked by ~q[i-1].
//   - Reset:
//     - While rst == 0, every stage is forced to 0 immediately, with no clk edge required.
//     - Reset overrides any clk edge that arrives at the same time.
//   - Reset release:
//     - q holds 0 until the first rising clk edge while rst == 1.
//     - That first edge gives q = 1.
//   - Counting: the count rises by one per rising clk edge, modulo 2^WIDTH.
//   - Wrap-around: from 2^WIDTH-1 (4'b1111) the next edge gives 0; all stages ripple-clear in turn.
//   - Latency and settling:
//     - q[0] changes one flop delay after the clk edge.
//     - Bit i settles (i+1) flop delays after the edge.
//     - Transient intermediate codes are legal while the ripple propagates (e.g. 0111 -> 0110 -> 0100 -> 0000 -> 1000).
//     - q is defined as valid once settled and before the next rising clk edge.
//   - Reset mid-count: asserting rst at any count clears q to 0 asynchronously; counting resumes from 0 after release.
//   - The falling edge of clk has no effect.
//   - There is no enable, load or direction control.
// CONFIGURATION
//   Macro ASYNC_COUNTER_TC_EN:
//   - Defined:
//     - Adds output tc.
//     - tc = 1 when q == all ones (4'b1111), else 0; decoded combinationally from q.
//     - tc may glitch during ripple settling.
//     - tc is 0 while in reset.
//   - Undefined: port tc does not exist; all other behaviour is identical.
// TESTING
//   (clk period 10 ns; check q just before each rising edge.)
//   1. Hold rst = 0 for 3 clk cycles -> q = 0000 throughout, no increments.
//   2. Release rst, apply 15 rising edges -> q = 1, 2, ..., 15 in order, one step per edge, no skips.
//   3. From q = 15, one more edge -> q = 0 (wrap). With ASYNC_COUNTER_TC_EN: tc 1 -> 0.
//   4. At q = 9, pull rst low mid-period with clk held stable -> q = 0000 within the flop delay;
//      release, then 1 edge -> q = 1.
//   5. Release rst, apply 20 edges -> q = 4 (20 mod 16).
//   6. With ASYNC_COUNTER_TC_EN: sweep 0..15 -> tc = 1 only at q = 15 and 0 at every other count.

Source files
------------

// File: rtl/async_counter_4bit.sv
// async_counter_4bit: WIDTH-bit ripple up-counter with asynchronous active-low reset
//   clk : count clock, each rising edge advances q by one
//   rst : asynchronous reset, active-low (0 clears every stage at once)
//   q   : current count, q[0] is the LSB
//   tc  : terminal count (q all ones), only when ASYNC_COUNTER_TC_EN is defined
module async_counter_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
`ifdef ASYNC_COUNTER_TC_EN
    ,
    output logic             tc
`endif
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic stage_clk;
        logic r;
        if (i == 0) begin : g_first
            assign stage_clk = clk;
        end else begin : g_next
            // a rising edge of ~q[i-1] is the 1->0 carry out of the previous stage
            assign stage_clk = ~q[i-1];
        end
        always_ff @(posedge stage_clk or negedge rst)
            if (!rst) r <= 1'b0;
            else      r <= ~r;
        assign q[i] = r;
    end
`ifdef ASYNC_COUNTER_TC_EN
    assign tc = &q;
`endif
endmodule

// File: tb/tb_async_counter_4bit.sv
// tb_async_counter_4bit: directed, table-driven self-checking bench for async_counter_4bit
module tb_async_counter_4bit;
    logic       clk;
    logic       rst;
    logic [3:0] q;
`ifdef ASYNC_COUNTER_TC_EN
    logic       tc;
`endif
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst_v;
        int         edges;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[19];

    async_counter_4bit dut (
        .clk (clk),
        .rst (rst),
        .q   (q)
`ifdef ASYNC_COUNTER_TC_EN
        ,
        .tc  (tc)
`endif
    );

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_tc(input string name, input logic [3:0] exp_q);
`ifdef ASYNC_COUNTER_TC_EN
        check(name, {3'b000, tc}, {3'b000, exp_q == 4'hf});
`endif
    endtask

    // one full 10 ns clock period, ending 1 ns before the next rising edge
    task automatic pulse();
        #1 clk = 1'b1;
        #5 clk = 1'b0;
        #4;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) vecs[k] = '{1'b0, 1, 4'd0};
        for (int k = 1; k < 16; k++) vecs[k + 2] = '{1'b1, 1, 4'(k)};
        vecs[18] = '{1'b1, 1, 4'd0};
        #3;
        check("reset_initial", q, 4'd0);
        check_tc("tc_reset_initial", 4'd0);
        for (int k = 0; k < 19; k++) begin
            rst = vecs[k].rst_v;
            #1;
            repeat (vecs[k].edges) pulse();
            check($sformatf("vec%0d_q", k), q, vecs[k].exp);
            check_tc($sformatf("vec%0d_tc", k), vecs[k].exp);
        end
        // async reset mid-count with clk held low
        rst = 1'b0; #1; rst = 1'b1; #1;
        repeat (9) pulse();
        check("count_to_9", q, 4'd9);
        #2 rst = 1'b0;
        #1 check("async_clear_at_9", q, 4'd0);
        check_tc("tc_in_reset", 4'd0);
        #3 rst = 1'b1;
        #1 pulse();
        check("first_edge_after_release", q, 4'd1);
        // twenty edges from zero wraps once
        rst = 1'b0; #2 rst = 1'b1; #1;
        repeat (20) pulse();
        check("twenty_edges", q, 4'd4);
        // only the rising edge counts
        #1 clk = 1'b1;
        #4 check("rise_counts", q, 4'd5);
        clk = 1'b0;
        #4 check("fall_ignored", q, 4'd5);
        // reset wins over a coincident rising edge
        rst = 1'b0;
        clk = 1'b1;
        #1 check("reset_beats_edge", q, 4'd0);
        #3 clk = 1'b0;
        #2 rst = 1'b1;
        #1 pulse();
        check("edge_after_coincident_reset", q, 4'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
